dec_secded_pipe: RTL and testbench

// - Downstream consumer of the encoder: 2-stage pipelined SECDED decoder for 8/16/32-bit codewords.
// - Recomputes parity, forms syndrome, corrects single-bit errors, flags double errors.
// - Keeps saturating error statistics. valid/ready on both sides; full throughput.

---
 rtl/enc_dec_pkg.sv | 79 +++++++
 rtl/dec_syndrome.sv | 34 +++
 rtl/dec_secded_pipe.sv | 134 +++++++++++++
 tb/tb_dec_secded_pipe.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_dec_pkg.sv
// Shared SECDED definitions: width selector, Hamming check masks over the payload
// and syndrome-to-codeword-bit mapping, common to the encoder and decoder.
package enc_dec_pkg;

  typedef enum logic [1:0] {W8 = 2'b00, W16 = 2'b01, W32 = 2'b10} width_sel_t;

  localparam int MAX_CW_BITS   = 32;
  localparam int MAX_DATA_BITS = 26;
  localparam int MAX_CHK_BITS  = 5;

  localparam int DATA_BITS_W8  = 4;
  localparam int DATA_BITS_W16 = 11;
  localparam int DATA_BITS_W32 = 26;
  localparam int PAR_BITS_W8   = 4;
  localparam int PAR_BITS_W16  = 5;
  localparam int PAR_BITS_W32  = 6;

  function automatic width_sel_t to_width(input logic [1:0] code);
    case (code)
      2'b00:   return W8;
      2'b01:   return W16;
      default: return W32;
    endcase
  endfunction

  function automatic int data_bits(input width_sel_t w);
    case (w)
      W8:      return DATA_BITS_W8;
      W16:     return DATA_BITS_W16;
      default: return DATA_BITS_W32;
    endcase
  endfunction

  function automatic int par_bits(input width_sel_t w);
    case (w)
      W8:      return PAR_BITS_W8;
      W16:     return PAR_BITS_W16;
      default: return PAR_BITS_W32;
    endcase
  endfunction

  // Payload bit i sits at the i-th non-power-of-two Hamming position (3,5,6,7,9,...).
  function automatic int data_hpos(input int i);
    int n;
    int hpos;
    n    = 0;
    hpos = 0;
    for (int p = 3; p < 64; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == i && hpos == 0) hpos = p;
        n++;
      end
    end
    return hpos;
  endfunction

  function automatic logic [MAX_DATA_BITS-1:0] chk_mask(input width_sel_t w, input int j);
    logic [MAX_DATA_BITS-1:0] m;
    int hp;
    m = '0;
    for (int i = 0; i < MAX_DATA_BITS; i++) begin
      hp = data_hpos(i);
      if (i < data_bits(w) && j < par_bits(w) - 1) m[i] = hp[j];
    end
    return m;
  endfunction

  // Codeword layout: checks in [k-1:0], overall parity at [k], payload above.
  function automatic logic [5:0] syn2pos(input width_sel_t w, input logic [4:0] syn);
    int lg;
    int pos;
    lg = 0;
    for (int j = 0; j < MAX_CHK_BITS; j++) if (syn[j]) lg = j;
    if (syn == 5'(1 << lg)) pos = lg;
    else                    pos = par_bits(w) - 2 + int'(syn) - lg;
    return 6'(pos);
  endfunction

endpackage

// File: rtl/dec_syndrome.sv
// Combinational syndrome and overall-parity evaluation of a width-masked codeword.
module dec_syndrome
  import enc_dec_pkg::*;
(
  input  logic [1:0]  i_width,
  input  logic [31:0] i_cw,
  output logic [4:0]  o_syn,
  output logic        o_ovp
);

  logic [MAX_DATA_BITS-1:0] w_d8, w_d16, w_d32;
  logic [4:0]               w_c8, w_c16, w_c32;

  assign w_d8  = MAX_DATA_BITS'(i_cw[7:4]);
  assign w_d16 = MAX_DATA_BITS'(i_cw[15:5]);
  assign w_d32 = i_cw[31:6];

  for (genvar j = 0; j < MAX_CHK_BITS; j++) begin : g_chk
    assign w_c8[j]  = ^(w_d8  & chk_mask(W8,  j));
    assign w_c16[j] = ^(w_d16 & chk_mask(W16, j));
    assign w_c32[j] = ^(w_d32 & chk_mask(W32, j));
  end

  always_comb begin
    case (to_width(i_width))
      W8:      o_syn = w_c8  ^ 5'(i_cw[2:0]);
      W16:     o_syn = w_c16 ^ 5'(i_cw[3:0]);
      default: o_syn = w_c32 ^ i_cw[4:0];
    endcase
  end

  assign o_ovp = ^i_cw;

endmodule

// File: rtl/dec_secded_pipe.sv
// Two-stage SECDED decoder for 8/16/32-bit codewords with valid/ready flow control
// and saturating single/double error counters.
module dec_secded_pipe
  import enc_dec_pkg::*;
#(
  parameter int AMBA_WORD  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            CODEWORD_WIDTH,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [AMBA_WORD-1:0]  codeword_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            num_of_errors,
  input  logic                  clr_cnt,
  output logic [CNT_W-1:0]      sec_cnt,
  output logic [CNT_W-1:0]      ded_cnt
);

  logic [31:0]              w_bus, w_cw_in, w_flip, w_fixed;
  width_sel_t               w_width_in;
  logic [4:0]               w_syn_in;
  logic                     w_ovp_in, w_s2_en, w_load;
  logic [5:0]               w_pos;
  logic [1:0]               w_num;
  logic [MAX_DATA_BITS-1:0] w_payload;

  logic                  r_vld_p1, r_ovp_p1, r_vld_p2;
  width_sel_t            r_width_p1;
  logic [31:0]           r_cw_p1;
  logic [4:0]            r_syn_p1;
  logic [DATA_WIDTH-1:0] r_data_p2;
  logic [1:0]            r_num_p2;
  logic [CNT_W-1:0]      r_sec, r_ded;

  assign w_bus = codeword_in[31:0];

  always_comb begin
    w_width_in = to_width(CODEWORD_WIDTH);
    case (w_width_in)
      W8:      w_cw_in = {24'd0, w_bus[7:0]};
      W16:     w_cw_in = {16'd0, w_bus[15:0]};
      default: w_cw_in = w_bus;
    endcase
  end

  dec_syndrome u_syn (
    .i_width (CODEWORD_WIDTH),
    .i_cw    (w_cw_in),
    .o_syn   (w_syn_in),
    .o_ovp   (w_ovp_in)
  );

  assign w_s2_en  = !r_vld_p2 || out_ready;
  assign in_ready = !r_vld_p1 || w_s2_en;
  assign w_load   = w_s2_en && r_vld_p1;

  // Stage 1: capture masked codeword with its syndrome and overall parity
  always_ff @(posedge clk) begin
    if (rst)           r_vld_p1 <= 1'b0;
    else if (in_ready) r_vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      r_width_p1 <= w_width_in;
      r_cw_p1    <= w_cw_in;
      r_syn_p1   <= w_syn_in;
      r_ovp_p1   <= w_ovp_in;
    end
  end

  // An odd-weight error with a syndrome pointing past the codeword is really a multi-bit error.
  always_comb begin
    w_flip = '0;
    w_num  = 2'd0;
    w_pos  = syn2pos(r_width_p1, r_syn_p1);
    if (r_ovp_p1) begin
      if (r_syn_p1 == '0) begin
        w_num = 2'd1;
      end else if (int'(w_pos) < par_bits(r_width_p1) + data_bits(r_width_p1)) begin
        w_num  = 2'd1;
        w_flip = 32'd1 << w_pos;
      end else begin
        w_num = 2'd2;
      end
    end else if (r_syn_p1 != '0) begin
      w_num = 2'd2;
    end
    w_fixed = r_cw_p1 ^ w_flip;
    case (r_width_p1)
      W8:      w_payload = MAX_DATA_BITS'(w_fixed[7:4]);
      W16:     w_payload = MAX_DATA_BITS'(w_fixed[15:5]);
      default: w_payload = w_fixed[31:6];
    endcase
  end

  // Stage 2: corrected payload and classification
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p2  <= 1'b0;
      r_data_p2 <= '0;
      r_num_p2  <= 2'd0;
    end else if (w_s2_en) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_data_p2 <= DATA_WIDTH'(w_payload);
        r_num_p2  <= w_num;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      r_sec <= '0;
      r_ded <= '0;
    end else if (w_load) begin
      if (w_num == 2'd1 && r_sec != '1) r_sec <= r_sec + CNT_W'(1);
      if (w_num == 2'd2 && r_ded != '1) r_ded <= r_ded + CNT_W'(1);
    end
  end

  assign out_valid     = r_vld_p2;
  assign data_out      = r_data_p2;
  assign num_of_errors = r_num_p2;
  assign sec_cnt       = r_sec;
  assign ded_cnt       = r_ded;

endmodule

// File: tb/tb_dec_secded_pipe.sv
// Directed bench for dec_secded_pipe: encoder model builds codewords, tests flip bits.
module tb_dec_secded_pipe;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       CODEWORD_WIDTH;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      codeword_in;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      data_out;
  logic [1:0]       num_of_errors;
  logic             clr_cnt;
  logic [CNT_W-1:0] sec_cnt;
  logic [CNT_W-1:0] ded_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dec_secded_pipe #(.AMBA_WORD(32), .DATA_WIDTH(32), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .CODEWORD_WIDTH (CODEWORD_WIDTH),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .codeword_in    (codeword_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .data_out       (data_out),
    .num_of_errors  (num_of_errors),
    .clr_cnt        (clr_cnt),
    .sec_cnt        (sec_cnt),
    .ded_cnt        (ded_cnt)
  );

  // Encoder model: checks = XOR of Hamming positions of set payload bits.
  function automatic logic [31:0] enc(input logic [1:0] w, input logic [25:0] d);
    int k, nd, p;
    logic [4:0] chk;
    logic ovp;
    k  = (w == 2'b00) ? 3 : (w == 2'b01) ? 4 : 5;
    nd = (w == 2'b00) ? 4 : (w == 2'b01) ? 11 : 26;
    chk = '0;
    ovp = 1'b0;
    p = 3;
    for (int i = 0; i < nd; i++) begin
      while ((p & (p - 1)) == 0) p++;
      if (d[i]) begin
        chk ^= p[4:0];
        ovp ^= 1'b1;
      end
      p++;
    end
    ovp ^= ^chk;
    return (32'(d) << (k + 1)) | (32'(ovp) << k) | 32'(chk);
  endfunction

  task automatic send_one(input logic [1:0] w, input logic [31:0] cw,
                          output logic v1, output logic v2,
                          output logic [31:0] d, output logic [1:0] n);
    @(negedge clk);
    CODEWORD_WIDTH = w;
    codeword_in    = cw;
    in_valid       = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    v1 = out_valid;
    @(negedge clk);
    v2 = out_valid;
    d  = data_out;
    n  = num_of_errors;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
    codeword_in = '0; CODEWORD_WIDTH = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", data_out); end
    checks++; if (num_of_errors !== 2'd0) begin errors++; $display("FAIL reset_num got %0d exp 0", num_of_errors); end
    checks++; if (sec_cnt !== '0) begin errors++; $display("FAIL reset_sec got %0d exp 0", sec_cnt); end
    checks++; if (ded_cnt !== '0) begin errors++; $display("FAIL reset_ded got %0d exp 0", ded_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_clean;
    logic v1, v2; logic [31:0] d; logic [1:0] n;
    send_one(2'b01, enc(2'b01, 26'h5A3), v1, v2, d, n);
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL clean_lat1 got %b exp 0", v1); end
    checks++; if (v2 !== 1'b1) begin errors++; $display("FAIL clean_lat2 got %b exp 1", v2); end
    checks++; if (d !== 32'h5A3) begin errors++; $display("FAIL clean_data got %h exp 5a3", d); end
    checks++; if (n !== 2'd0) begin errors++; $display("FAIL clean_num got %0d exp 0", n); end
    checks++; if (sec_cnt !== 8'd0) begin errors++; $display("FAIL clean_sec got %0d exp 0", sec_cnt); end
    checks++; if (ded_cnt !== 8'd0) begin errors++; $display("FAIL clean_ded got %0d exp 0", ded_cnt); end
  endtask

  task automatic test_single;
    logic v1, v2; logic [31:0] d; logic [1:0] n;
    send_one(2'b10, enc(2'b10, 26'h2ABCDEF) ^ (32'd1 << 16), v1, v2, d, n);
    checks++; if (d !== 32'h2ABCDEF) begin errors++; $display("FAIL single_data got %h exp 2abcdef", d); end
    checks++; if (n !== 2'd1) begin errors++; $display("FAIL single_num got %0d exp 1", n); end
    checks++; if (sec_cnt !== 8'd1) begin errors++; $display("FAIL single_sec got %0d exp 1", sec_cnt); end
    send_one(2'b10, enc(2'b10, 26'h2ABCDEF) ^ (32'd1 << 5), v1, v2, d, n);
    checks++; if (d !== 32'h2ABCDEF) begin errors++; $display("FAIL ovp_data got %h exp 2abcdef", d); end
    checks++; if (n !== 2'd1) begin errors++; $display("FAIL ovp_num got %0d exp 1", n); end
    checks++; if (sec_cnt !== 8'd2) begin errors++; $display("FAIL ovp_sec got %0d exp 2", sec_cnt); end
    send_one(2'b01, enc(2'b01, 26'h5A3) ^ 32'h4, v1, v2, d, n);
    checks++; if (d !== 32'h5A3) begin errors++; $display("FAIL chkbit_data got %h exp 5a3", d); end
    checks++; if (n !== 2'd1) begin errors++; $display("FAIL chkbit_num got %0d exp 1", n); end
    checks++; if (sec_cnt !== 8'd3) begin errors++; $display("FAIL chkbit_sec got %0d exp 3", sec_cnt); end
  endtask

  task automatic test_double;
    logic v1, v2; logic [31:0] d; logic [1:0] n;
    // data 4'h9 encodes to 8'h9C; bits 1 and 6 flipped give 8'hDE
    send_one(2'b00, 32'h0000_00DE, v1, v2, d, n);
    checks++; if (d !== 32'hD) begin errors++; $display("FAIL double_data got %h exp d", d); end
    checks++; if (n !== 2'd2) begin errors++; $display("FAIL double_num got %0d exp 2", n); end
    checks++; if (ded_cnt !== 8'd1) begin errors++; $display("FAIL double_ded got %0d exp 1", ded_cnt); end
    checks++; if (sec_cnt !== 8'd3) begin errors++; $display("FAIL double_sec got %0d exp 3", sec_cnt); end
    send_one(2'b00, 32'h1234_569C, v1, v2, d, n);
    checks++; if (d !== 32'h9) begin errors++; $display("FAIL highbits_data got %h exp 9", d); end
    checks++; if (n !== 2'd0) begin errors++; $display("FAIL highbits_num got %0d exp 0", n); end
  endtask

  task automatic test_backpressure;
    logic [1:0]  ws[6];
    logic [31:0] cws[6];
    logic [31:0] exd[6];
    logic [1:0]  exn[6];
    int idx, oidx, stall_acc;
    logic saw_block, acc;
    ws[0] = 2'b00; cws[0] = enc(2'b00, 26'h5);                 exd[0] = 32'h5;       exn[0] = 2'd0;
    ws[1] = 2'b01; cws[1] = enc(2'b01, 26'h7FF) ^ 32'h20;      exd[1] = 32'h7FF;     exn[1] = 2'd1;
    ws[2] = 2'b10; cws[2] = enc(2'b10, 26'h3FFFFFF);           exd[2] = 32'h3FFFFFF; exn[2] = 2'd0;
    ws[3] = 2'b00; cws[3] = 32'h0000_002B;                     exd[3] = 32'h2;       exn[3] = 2'd2;
    ws[4] = 2'b01; cws[4] = enc(2'b01, 26'h123) ^ 32'h10;      exd[4] = 32'h123;     exn[4] = 2'd1;
    ws[5] = 2'b11; cws[5] = enc(2'b10, 26'h1234567) ^ 32'h1;   exd[5] = 32'h1234567; exn[5] = 2'd1;
    idx = 0; oidx = 0; stall_acc = 0; saw_block = 1'b0;
    for (int c = 0; c < 40 && oidx < 6; c++) begin
      @(negedge clk);
      out_ready = (c >= 5);
      in_valid  = (idx < 6);
      if (idx < 6) begin
        CODEWORD_WIDTH = ws[idx];
        codeword_in    = cws[idx];
      end
      #1;
      if (out_valid && out_ready) begin
        checks++; if (data_out !== exd[oidx]) begin errors++; $display("FAIL bp_data[%0d] got %h exp %h", oidx, data_out, exd[oidx]); end
        checks++; if (num_of_errors !== exn[oidx]) begin errors++; $display("FAIL bp_num[%0d] got %0d exp %0d", oidx, num_of_errors, exn[oidx]); end
        oidx++;
      end
      if (!out_ready && in_valid && in_ready) stall_acc++;
      if (!out_ready && !in_ready) saw_block = 1'b1;
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) idx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (oidx != 6) begin errors++; $display("FAIL bp_out_count got %0d exp 6", oidx); end
    checks++; if (idx != 6) begin errors++; $display("FAIL bp_in_count got %0d exp 6", idx); end
    checks++; if (stall_acc != 2) begin errors++; $display("FAIL bp_stall_accepts got %0d exp 2", stall_acc); end
    checks++; if (saw_block !== 1'b1) begin errors++; $display("FAIL bp_in_ready_drop got %b exp 1", saw_block); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got %b exp 0", out_valid); end
    checks++; if (sec_cnt !== 8'd6) begin errors++; $display("FAIL bp_sec got %0d exp 6", sec_cnt); end
    checks++; if (ded_cnt !== 8'd2) begin errors++; $display("FAIL bp_ded got %0d exp 2", ded_cnt); end
  endtask

  task automatic test_saturation;
    out_ready = 1'b1;
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; CODEWORD_WIDTH = 2'b00; codeword_in = 32'h9C ^ 32'h10;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (sec_cnt !== 8'hFF) begin errors++; $display("FAIL sat_sec got %h exp ff", sec_cnt); end
    checks++; if (num_of_errors !== 2'd1) begin errors++; $display("FAIL sat_num got %0d exp 1", num_of_errors); end
    @(negedge clk);
    in_valid = 1'b1; CODEWORD_WIDTH = 2'b00; codeword_in = 32'h0000_00DE;
    @(negedge clk);
    in_valid = 1'b0; clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    checks++; if (out_valid !== 1'b1 || num_of_errors !== 2'd2) begin errors++; $display("FAIL clr_word got v%b n%0d exp v1 n2", out_valid, num_of_errors); end
    checks++; if (ded_cnt !== 8'd0) begin errors++; $display("FAIL clr_ded got %0d exp 0", ded_cnt); end
    checks++; if (sec_cnt !== 8'd0) begin errors++; $display("FAIL clr_sec got %0d exp 0", sec_cnt); end
  endtask

  task automatic test_reset_mid;
    int extra;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; CODEWORD_WIDTH = 2'b10;
    codeword_in = enc(2'b10, 26'h0ABCDEF) ^ (32'd1 << 16);
    @(negedge clk);
    CODEWORD_WIDTH = 2'b01; codeword_in = enc(2'b01, 26'h5A3);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL rm_full got v%b r%b exp v1 r0", out_valid, in_ready); end
    checks++; if (sec_cnt !== 8'd1) begin errors++; $display("FAIL rm_sec_pre got %0d exp 1", sec_cnt); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready got %b exp 1", in_ready); end
    checks++; if (sec_cnt !== 8'd0 || ded_cnt !== 8'd0) begin errors++; $display("FAIL rm_cnt got %0d/%0d exp 0/0", sec_cnt, ded_cnt); end
    out_ready = 1'b1;
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL rm_flushed got %0d words exp 0", extra); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single();
    test_double();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
